// File: rtl/toggle_arbiter_if.sv
// ---------------------------------------------------------------------------
// toggle_arbiter_if -- requester-side bus of the toggle arbiter.
//
// Signals (NREQ requesters, WIDTH-bit shared T-register bank):
//   req    [NREQ-1:0]       request from requester i on bit i
//   mask   [NREQ*WIDTH-1:0] toggle mask of requester i on [i*WIDTH +: WIDTH]
//   gnt    [NREQ-1:0]       one-hot grant
//   ack    [NREQ-1:0]       one-cycle completion pulse to the granted requester
//   q      [WIDTH-1:0]      shared T-register bank state
//   busy                    arbiter is not idle
//   parity                  XOR-reduction of q (only with TOGGLE_ARBITER_PARITY_EN)
//
// Modports: master = requester side, slave = arbiter side.
// Optional feature macro: TOGGLE_ARBITER_PARITY_EN.
// ---------------------------------------------------------------------------
interface toggle_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] mask;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic                  busy;
`ifdef TOGGLE_ARBITER_PARITY_EN
    logic                  parity;
`endif

    modport master (
        output req,
        output mask,
        input  gnt,
        input  ack,
        input  q,
`ifdef TOGGLE_ARBITER_PARITY_EN
        input  parity,
`endif
        input  busy
    );

    modport slave (
        input  req,
        input  mask,
        output gnt,
        output ack,
        output q,
`ifdef TOGGLE_ARBITER_PARITY_EN
        output parity,
`endif
        output busy
    );
endinterface

// File: rtl/toggle_arbiter.sv
// ---------------------------------------------------------------------------
// toggle_arbiter -- round-robin arbiter granting NREQ requesters access to a
// shared bank of WIDTH T-flip-flops. Each operation takes four cycles:
// IDLE (arbitrate) -> GRANT (latch winner's mask) -> TOGGLE (q ^= mask)
// -> DONE (ack pulse, advance round-robin pointer) -> IDLE.
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : toggle_arbiter_if.slave (req, mask in; gnt, ack, q, busy out;
//          parity out when TOGGLE_ARBITER_PARITY_EN is defined)
//
// All outputs come straight from flops.
// Optional feature macro: TOGGLE_ARBITER_PARITY_EN adds the parity output.
// ---------------------------------------------------------------------------
module toggle_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    toggle_arbiter_if.slave   bus
);
    localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;
    localparam logic [PW:0]   NREQ_W   = (PW+1)'(NREQ);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        TOGGLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Even-parity helper over the bank state.
    function automatic logic parity_of(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  mlat_q, mlat_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     win_q, win_d;
    logic              busy_q, busy_d;
`ifdef TOGGLE_ARBITER_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic              pick_found;
    logic [PW-1:0]     pick_idx;
    logic [PW:0]       cand;
    logic [WIDTH-1:0]  sel_mask;

    // Round-robin search: first requester at or after ptr, wrapping at NREQ-1.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = {PW{1'b0}};
        cand       = {(PW+1){1'b0}};
        for (int off = 0; off < NREQ; off++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(off);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end else begin
                cand = cand;
            end
            if (!pick_found && bus.req[cand[PW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[PW-1:0];
            end else begin
                pick_found = pick_found;
            end
        end
    end

    // Mask of the currently granted requester (gnt is one-hot, so AND-OR mux).
    always_comb begin
        sel_mask = {WIDTH{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            sel_mask = sel_mask | (bus.mask[i*WIDTH +: WIDTH] & {WIDTH{gnt_q[i]}});
        end
    end

    // FSM next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ack_d   = {NREQ{1'b0}};
        q_d     = q_q;
        mlat_d  = mlat_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    win_d   = pick_idx;
                    gnt_d   = NREQ'(1) << pick_idx;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                // Mask is captured here so a requester dropping req later
                // cannot change or abort the operation.
                mlat_d  = sel_mask;
                state_d = TOGGLE;
            end
            TOGGLE: begin
                q_d     = q_q ^ mlat_q;
                ack_d   = gnt_q;
                state_d = DONE;
            end
            DONE: begin
                ptr_d   = (win_q == LAST_IDX) ? {PW{1'b0}} : (win_q + PW'(1));
                gnt_d   = {NREQ{1'b0}};
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = {NREQ{1'b0}};
            end
        endcase
        busy_d = (state_d != IDLE);
`ifdef TOGGLE_ARBITER_PARITY_EN
        parity_d = parity_of(q_d);
`endif
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= {NREQ{1'b0}};
            ack_q    <= {NREQ{1'b0}};
            q_q      <= {WIDTH{1'b0}};
            mlat_q   <= {WIDTH{1'b0}};
            ptr_q    <= {PW{1'b0}};
            win_q    <= {PW{1'b0}};
            busy_q   <= 1'b0;
`ifdef TOGGLE_ARBITER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            q_q      <= q_d;
            mlat_q   <= mlat_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            busy_q   <= busy_d;
`ifdef TOGGLE_ARBITER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.ack  = ack_q;
    assign bus.q    = q_q;
    assign bus.busy = busy_q;
`ifdef TOGGLE_ARBITER_PARITY_EN
    assign bus.parity = parity_q;
`endif

endmodule

// File: tb/tb_toggle_arbiter.sv
// ---------------------------------------------------------------------------
// tb_toggle_arbiter -- directed and random checks of toggle_arbiter
// (NREQ=4, WIDTH=8) against an operation-level reference model.
// ---------------------------------------------------------------------------
module tb_toggle_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    toggle_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();
    toggle_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: cycles elapsed in the current operation, the winner,
    // the round-robin start point, the bank value and the latched mask.
    int         m_age;
    int         m_win;
    int         m_ptr;
    logic [7:0] m_q;
    logic [7:0] m_lat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        m_age = 0; m_win = 0; m_ptr = 0; m_q = 8'h00; m_lat = 8'h00;
    endtask

    // One rising edge of the reference: arbitrate, latch, toggle, finish.
    task automatic model_edge(input logic [3:0] r, input logic [31:0] mk);
        bit found;
        int idx;
        case (m_age)
            0: begin
                if (r != 4'b0000) begin
                    found = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        idx = (m_ptr + k) % 4;
                        if (!found && r[idx]) begin
                            m_win = idx;
                            found = 1'b1;
                        end
                    end
                    m_age = 1;
                end
            end
            1: begin m_lat = mk[m_win*8 +: 8]; m_age = 2; end
            2: begin m_q = m_q ^ m_lat; m_age = 3; end
            default: begin m_ptr = (m_win + 1) % 4; m_age = 0; end
        endcase
    endtask

    task automatic compare_all();
        logic [3:0] one;
        one = 4'b0001 << m_win;
        check("gnt",  64'(bus.gnt),  64'((m_age != 0) ? one : 4'b0000));
        check("ack",  64'(bus.ack),  64'((m_age == 3) ? one : 4'b0000));
        check("q",    64'(bus.q),    64'(m_q));
        check("busy", 64'(bus.busy), 64'(m_age != 0));
`ifdef TOGGLE_ARBITER_PARITY_EN
        check("parity", 64'(bus.parity), 64'(^m_q));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(bus.req, bus.mask);
        cyc++;
        @(negedge clk);
        compare_all();
    endtask

    // Hold r until ack, then one more edge back to IDLE, then drop req.
    task automatic run_op(input logic [3:0] r, output int win, output logic [7:0] qack,
                          output int gcnt, output int acnt);
        bit seen;
        seen = 1'b0; gcnt = 0; acnt = 0; win = -1; qack = 8'h00;
        bus.req = r;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (bus.gnt === r) gcnt++;
            if (bus.ack !== 4'b0000) begin
                if (bus.ack === r) acnt++;
                seen = 1'b1;
                qack = bus.q;
                win  = oh2idx(bus.ack);
            end
        end
        check("op_timeout", 64'(seen), 64'd1);
        tick();
        if (bus.gnt === r) gcnt++;
        if (bus.ack === r) acnt++;
        bus.req = 4'b0000;
    endtask

    int         win, gcnt, acnt;
    logic [7:0] qack;
    int         g_idx[$];
    int         g_cyc[$];
    int         exp_order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] prev_gnt;

    initial begin
        bus.req  = 4'b0000;
        bus.mask = 32'h0000_0000;
        rst      = 1'b1;
        model_reset();
        #1;
        check("rst_gnt",  64'(bus.gnt),  64'd0);
        check("rst_ack",  64'(bus.ack),  64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_q",    64'(bus.q),    64'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Single request, requester 2, mask A5 from q=0.
        bus.mask = {8'h11, 8'hA5, 8'h22, 8'h33};
        run_op(4'b0100, win, qack, gcnt, acnt);
        check("single_gnt_cycles", 64'(gcnt), 64'd3);
        check("single_ack_cycles", 64'(acnt), 64'd1);
        check("single_q",          64'(qack), 64'h A5);
        check("single_win",        64'(win),  64'd2);

        // Bring q to 3C via requester 0, then requester 1 toggles all bits twice.
        bus.mask = {8'h11, 8'hA5, 8'h22, 8'h99};
        run_op(4'b0001, win, qack, gcnt, acnt);
        check("setup_q3c", 64'(qack), 64'h3C);
        bus.mask = {8'h11, 8'hA5, 8'hFF, 8'h99};
        run_op(4'b0010, win, qack, gcnt, acnt);
        check("ff_first",  64'(qack), 64'hC3);
        run_op(4'b0010, win, qack, gcnt, acnt);
        check("ff_second", 64'(qack), 64'h3C);
        check("ff_win",    64'(win),  64'd1);

        // Zero mask from requester 3: acked, q unchanged, pointer wraps to 0.
        bus.mask = {8'h00, 8'hA5, 8'hFF, 8'h99};
        run_op(4'b1000, win, qack, gcnt, acnt);
        check("zero_ack_cycles", 64'(acnt), 64'd1);
        check("zero_q",          64'(qack), 64'h3C);
        check("zero_win",        64'(win),  64'd3);

        // All requesting continuously: grants 0,1,2,3,0 every 4 cycles.
        bus.mask = $urandom;
        bus.req  = 4'b1111;
        prev_gnt = bus.gnt;
        for (int i = 0; i < 30 && g_idx.size() < 5; i++) begin
            tick();
            if (bus.gnt !== 4'b0000 && prev_gnt === 4'b0000) begin
                g_idx.push_back(oh2idx(bus.gnt));
                g_cyc.push_back(cyc);
            end
            prev_gnt = bus.gnt;
        end
        bus.req = 4'b0000;
        check("rr_count", 64'(g_idx.size()), 64'd5);
        for (int k = 0; k < g_idx.size(); k++) check("rr_order", 64'(g_idx[k]), 64'(exp_order[k]));
        for (int k = 1; k < g_cyc.size(); k++) check("rr_spacing", 64'(g_cyc[k] - g_cyc[k-1]), 64'd4);
        for (int i = 0; i < 6 && bus.busy; i++) tick();
        check("rr_idle", 64'(bus.busy), 64'd0);

        // Reset in the middle of TOGGLE with q=0F.
        bus.mask = {24'h000000, m_q ^ 8'h0F};
        run_op(4'b0001, win, qack, gcnt, acnt);
        check("pre_rst_q", 64'(qack), 64'h0F);
        bus.mask = 32'h0000_00FF;
        bus.req  = 4'b0001;
        tick();
        tick();
        check("pre_rst_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        model_reset();
        bus.req = 4'b0000;
        #1;
        check("mid_rst_q",    64'(bus.q),    64'd0);
        check("mid_rst_gnt",  64'(bus.gnt),  64'd0);
        check("mid_rst_ack",  64'(bus.ack),  64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        tick();
        rst  = 1'b0;
        acnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.ack !== 4'b0000) acnt++;
        end
        check("post_rst_no_ack", 64'(acnt),  64'd0);
        check("post_rst_q",      64'(bus.q), 64'd0);

`ifdef TOGGLE_ARBITER_PARITY_EN
        // Parity follows q in the same cycle q updates.
        bus.mask = 32'h0000_0001;
        bus.req  = 4'b0001;
        tick();
        tick();
        check("par_before", 64'(bus.parity), 64'd0);
        tick();
        check("par_q",   64'(bus.q),      64'h01);
        check("par_ack", 64'(bus.ack),    64'h1);
        check("par_after", 64'(bus.parity), 64'd1);
        bus.req = 4'b0000;
        tick();
`endif

        // Random traffic with occasional reset, checked every cycle.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) bus.req  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) bus.mask = $urandom;
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                check("rand_rst_busy", 64'(bus.busy), 64'd0);
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
